// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out.
// A transfer that sees no ack within TIMEOUT strobe cycles is abandoned and reported as a timeout.
module wb_cmd_master #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_timeout,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              cyc_q, cyc_d;
   logic              stb_q, stb_d;
   logic              we_q, we_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       dat_q, dat_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_to_q, rsp_to_d;
   logic [31:0]       rsp_dat_q, rsp_dat_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_to_d    = rsp_to_q;
      rsp_dat_d   = rsp_dat_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               we_d    = cmd_we;
               sel_d   = cmd_sel;
               adr_d   = cmd_adr;
               dat_d   = cmd_dat;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               cnt_d   = '0;
               state_d = BUS;
            end
         end
         BUS: begin
            // Ack takes priority over an expiring counter in the same cycle.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
               rsp_to_d    = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (cnt_q == TO_LAST) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_dat_d   = 32'h0;
               rsp_to_d    = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_to_d    = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_to_q    <= 1'b0;
         rsp_dat_q   <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_to_q    <= rsp_to_d;
         rsp_dat_q   <= rsp_dat_d;
         cnt_q       <= cnt_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = stb_q;
   assign wbm_we_o    = we_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_timeout = rsp_to_q;
   assign rsp_dat     = rsp_dat_q;

endmodule
